mix_columns_iter: RTL and testbench

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

---
 rtl/Cipher_defs.sv | 26 ++
 rtl/mix_single_column.sv | 47 ++++
 rtl/mix_columns_iter.sv | 100 ++++++++++
 tb/tb_mix_columns_iter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/Cipher_defs.sv
// Shared AES cipher types: byte, column and [column][row] state, GF(2^8) reduction constant.
// Also hosts the mix_columns_iter FSM encoding and the xtime helper.
package Cipher_defs;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned NB     = 4;

   typedef logic [BYTE_W-1:0] byte_t;
   typedef byte_t   [0:NB-1]  column_t;
   typedef column_t [0:NB-1]  state_t;

   // Low byte of the AES polynomial x^8 + x^4 + x^3 + x + 1
   localparam byte_t GF_RED = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mc_fsm_e;

   // Multiply by x in GF(2^8), result stays 8 bits wide
   function automatic byte_t xtime(input byte_t b);
      return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_RED : byte_t'(0));
   endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational transform of one 4-byte AES column (MixColumns).
// With MIX_COLUMNS_INV_EN defined, i_inv selects InvMixColumns instead.
module mix_single_column
   import Cipher_defs::*;
(
`ifdef MIX_COLUMNS_INV_EN
   input  logic    i_inv,
`endif
   input  column_t i_col,
   output column_t o_col
);

   column_t w_x2;
   column_t w_fwd;
`ifdef MIX_COLUMNS_INV_EN
   column_t w_x4;
   column_t w_x8;
   column_t w_inv;
`endif

   // Row r uses the base coefficient row rotated right by r
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int R1 = (r + 1) % 4;
      localparam int R2 = (r + 2) % 4;
      localparam int R3 = (r + 3) % 4;

      assign w_x2[r]  = xtime(i_col[r]);
      assign w_fwd[r] = w_x2[r] ^ w_x2[R1] ^ i_col[R1] ^ i_col[R2] ^ i_col[R3];

`ifdef MIX_COLUMNS_INV_EN
      assign w_x4[r]  = xtime(w_x2[r]);
      assign w_x8[r]  = xtime(w_x4[r]);
      // 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3, built from 8x/4x/2x partial products
      assign w_inv[r] = (w_x8[r]  ^ w_x4[r]  ^ w_x2[r])
                      ^ (w_x8[R1] ^ w_x2[R1] ^ i_col[R1])
                      ^ (w_x8[R2] ^ w_x4[R2] ^ i_col[R2])
                      ^ (w_x8[R3] ^ i_col[R3]);
`endif
   end

`ifdef MIX_COLUMNS_INV_EN
   assign o_col = i_inv ? w_inv : w_fwd;
`else
   assign o_col = w_fwd;
`endif

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per cycle through a shared column mixer, 4-cycle latency.
// Optional inverse mode (inv port) when MIX_COLUMNS_INV_EN is defined.
module mix_columns_iter
   import Cipher_defs::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   in_valid,
   output logic   in_ready,
   input  state_t state_in,
`ifdef MIX_COLUMNS_INV_EN
   input  logic   inv,
`endif
   output logic   out_valid,
   input  logic   out_ready,
   output state_t state_out
);

   mc_fsm_e    r_fsm;
   logic [1:0] r_col;
   state_t     r_state;
   logic       r_out_valid;
`ifdef MIX_COLUMNS_INV_EN
   logic       r_mode;
`endif

   column_t    w_cur_col;
   column_t    w_mixed;
   logic       w_in_xfer;

   assign w_cur_col = r_state[r_col];

   mix_single_column u_mix (
`ifdef MIX_COLUMNS_INV_EN
      .i_inv (r_mode),
`endif
      .i_col (w_cur_col),
      .o_col (w_mixed)
   );

   // Ready reflects reset immediately so nothing is accepted while it is held
   assign in_ready  = rst_n && ((r_fsm == ST_IDLE) || ((r_fsm == ST_DONE) && out_ready));
   assign out_valid = r_out_valid && rst_n;
   assign state_out = r_state;
   assign w_in_xfer = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fsm       <= ST_IDLE;
         r_col       <= 2'd0;
         r_state     <= '0;
         r_out_valid <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
         r_mode      <= 1'b0;
`endif
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               if (w_in_xfer) begin
                  r_state <= state_in;
                  r_col   <= 2'd0;
                  r_fsm   <= ST_BUSY;
`ifdef MIX_COLUMNS_INV_EN
                  r_mode  <= inv;
`endif
               end
            end
            ST_BUSY: begin
               r_state[r_col] <= w_mixed;
               r_col          <= r_col + 2'd1;
               if (r_col == 2'd3) begin
                  r_fsm       <= ST_DONE;
                  r_out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               // Output handed off; back-to-back input restarts immediately
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  if (w_in_xfer) begin
                     r_state <= state_in;
                     r_col   <= 2'd0;
                     r_fsm   <= ST_BUSY;
`ifdef MIX_COLUMNS_INV_EN
                     r_mode  <= inv;
`endif
                  end else begin
                     r_fsm <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_fsm       <= ST_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter: GF(2^8) reference model, per-cycle monitor, directed and random traffic.
// Inverse-mode scenarios are compiled in when MIX_COLUMNS_INV_EN is defined.
module tb_mix_columns_iter;
   import Cipher_defs::*;

   logic   clk;
   logic   rst_n;
   logic   in_valid;
   logic   in_ready;
   logic   out_valid;
   logic   out_ready;
   logic   inv;
   state_t state_in;
   state_t state_out;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   bit rnd_bp   = 0;

   state_t exp_q[$];
   int     acc_q[$];
   bit     seen;

   mix_columns_iter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
`ifdef MIX_COLUMNS_INV_EN
      .inv       (inv),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] expv);
      n_checks++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Plain shift-and-add GF(2^8) multiply modulo 0x11B
   function automatic int gmul(input int a, input int b);
      int p = 0;
      for (int i = 0; i < 8; i++) begin
         if ((b & 1) != 0) p = p ^ a;
         a = a << 1;
         if ((a & 'h100) != 0) a = a ^ 'h11B;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic state_t model(input state_t s, input bit iv);
      int     cf[4];
      state_t o;
      if (iv) begin
         cf[0] = 14; cf[1] = 11; cf[2] = 13; cf[3] = 9;
      end else begin
         cf[0] = 2;  cf[1] = 3;  cf[2] = 1;  cf[3] = 1;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            int acc = 0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(cf[(j - r + 4) % 4], int'(s[c][j]));
            o[c][r] = 8'(acc);
         end
      return o;
   endfunction

   function automatic state_t bcast(input logic [31:0] col);
      state_t s;
      for (int c = 0; c < 4; c++) s[c] = col;
      return s;
   endfunction

   function automatic state_t rnd_state();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: handshake, latency and data checks on every cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         chk(in_ready == 1'b0, "reset_in_ready", 128'(in_ready), 128'(0));
         chk(out_valid == 1'b0, "reset_out_valid", 128'(out_valid), 128'(0));
         exp_q.delete();
         acc_q.delete();
         seen = 0;
      end else begin
         bit exp_ir;
         exp_ir = (exp_q.size() == 0) || (out_valid && out_ready);
         chk(in_ready == exp_ir, "in_ready", 128'(in_ready), 128'(exp_ir));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "spurious_out_valid", 128'(out_valid), 128'(0));
            end else begin
               if (!seen) begin
                  chk(cyc == acc_q[0] + 4, "latency", 128'(cyc - acc_q[0]), 128'(4));
                  seen = 1;
               end
               chk(state_out == exp_q[0], "state_out", state_out, exp_q[0]);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  void'(acc_q.pop_front());
                  seen = 0;
               end
            end
         end
         if (in_valid && in_ready) begin
`ifdef MIX_COLUMNS_INV_EN
            exp_q.push_back(model(state_in, inv));
`else
            exp_q.push_back(model(state_in, 1'b0));
`endif
            acc_q.push_back(cyc + 1);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Caller is at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input state_t s, input bit iv);
      int n = 0;
      in_valid = 1'b1;
      state_in = s;
      inv      = iv;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) chk(1'b0, "send_timeout", 128'(n), 128'(0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      if (!out_valid) chk(1'b0, "out_timeout", 128'(n), 128'(0));
   endtask

   state_t s1, e1, s2, e2, ra, rb, hold, fwd;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      inv       = 1'b0;
      state_in  = '0;
      s1 = bcast(32'hdb135345);
      e1 = bcast(32'h8e4da1bc);
      s2 = {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'h2d26314c};
      e2 = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h4d7ebdf8};

      // Pin the reference model to known FIPS-197 column vectors
      chk(model(s1, 1'b0) == e1, "model_fwd_s1", model(s1, 1'b0), e1);
      chk(model(s2, 1'b0) == e2, "model_fwd_s2", model(s2, 1'b0), e2);
      chk(model(e1, 1'b1) == s1, "model_inv_e1", model(e1, 1'b1), s1);

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk(in_ready == 1'b1, "idle_in_ready", 128'(in_ready), 128'(1));
      chk(out_valid == 1'b0, "idle_out_valid", 128'(out_valid), 128'(0));

      // Directed forward vectors
      sync();
      send(s1, 1'b0);
      wait_out();
      chk(state_out == e1, "dir_s1", state_out, e1);
      sync();
      send(s2, 1'b0);
      wait_out();
      chk(state_out == e2, "dir_s2", state_out, e2);

      // Back-pressure in DONE, then simultaneous output and input transfer
      sync();
      out_ready = 1'b0;
      ra = rnd_state();
      rb = rnd_state();
      send(ra, 1'b0);
      wait_out();
      hold = state_out;
      repeat (10) @(negedge clk);
      chk(state_out == hold, "hold_stable", state_out, hold);
      chk(in_ready == 1'b0, "hold_in_ready", 128'(in_ready), 128'(0));
      sync();
      out_ready = 1'b1;
      send(rb, 1'b0);
      wait_out();
      chk(state_out == model(rb, 1'b0), "b2b_result", state_out, model(rb, 1'b0));

      // in_valid pulsed while busy must be ignored
      sync();
      ra = rnd_state();
      send(ra, 1'b0);
      in_valid = 1'b1;
      state_in = rnd_state();
      sync();
      sync();
      in_valid = 1'b0;
      wait_out();
      chk(state_out == model(ra, 1'b0), "busy_ignore", state_out, model(ra, 1'b0));

      // Reset during the second busy cycle aborts the operation
      sync();
      send(rnd_state(), 1'b0);
      sync();
      rst_n = 1'b0;
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      chk(out_valid == 1'b0, "abort_out_valid", 128'(out_valid), 128'(0));
      chk(in_ready == 1'b1, "abort_idle", 128'(in_ready), 128'(1));
      repeat (8) @(negedge clk);

`ifdef MIX_COLUMNS_INV_EN
      sync();
      send(e1, 1'b1);
      wait_out();
      chk(state_out == s1, "dir_inv_e1", state_out, s1);
      sync();
      ra = rnd_state();
      send(ra, 1'b0);
      wait_out();
      fwd = state_out;
      sync();
      send(fwd, 1'b1);
      wait_out();
      chk(state_out == ra, "round_trip", state_out, ra);
`endif

      // Random traffic with random downstream back-pressure
      sync();
      rnd_bp = 1;
      for (int i = 0; i < 20; i++) begin
`ifdef MIX_COLUMNS_INV_EN
         send(rnd_state(), 1'($urandom_range(0, 1)));
`else
         send(rnd_state(), 1'b0);
`endif
         repeat ($urandom_range(0, 3)) sync();
      end
      rnd_bp = 0;
      sync();
      out_ready = 1'b1;
      repeat (12) @(negedge clk);
      chk(exp_q.size() == 0, "drain", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
